// File: rtl/pipe_lzc_pkg.sv
// pipe_lzc_pkg: shared sizing helpers and leaf width for the pipelined leading-zero counter
package pipe_lzc_pkg;

    localparam int LZC_LEAF_W = 6;

    function automatic int lzc_latency(input int size);
        return size < 7 ? 1 : ($clog2(size - 2) + 1) / 2;
    endfunction

    function automatic int lzc_out_size(input int size);
        return $clog2(size + 1);
    endfunction

    // number of tree nodes left at a given merge level
    function automatic int lzc_nodes(input int leaves, input int level);
        return (leaves + (1 << level) - 1) >> level;
    endfunction

endpackage

// File: rtl/pipe_lzc_leaf.sv
// lzc_leaf: combinational leading-zero count of one chunk of up to six bits
module lzc_leaf import pipe_lzc_pkg::*; #(
    parameter int W = LZC_LEAF_W
) (
    input  logic [W-1:0] d,
    output logic [2:0]   cnt,
    output logic         zero
);

    // scan upward so the highest set bit decides the final count
    always_comb begin
        cnt = 3'(W);
        for (int i = 0; i < W; i++) cnt = d[i] ? 3'(W - 1 - i) : cnt;
    end

    assign zero = ~|d;

endmodule

// File: rtl/pipe_lzc.sv
// pipe_lzc: pipelined leading-zero counter; define PIPE_LZC_VALID_EN to carry a valid bit alongside the data
module pipe_lzc import pipe_lzc_pkg::*; #(
    parameter int    SIZE     = 64,
    parameter int    OUT_SIZE = lzc_out_size(SIZE),
    parameter string FAMILY   = "Stratix 10"
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SIZE-1:0]     din,
    output logic [OUT_SIZE-1:0] dout
`ifdef PIPE_LZC_VALID_EN
    ,
    input  logic                din_valid,
    output logic                dout_valid
`endif
);

    localparam int LAT    = lzc_latency(SIZE);
    localparam int LEAVES = (SIZE + LZC_LEAF_W - 1) / LZC_LEAF_W;
    localparam int LEVELS = $clog2(LEAVES);
    // stages not needed by the tree become a plain delay in front of dout
    localparam int TAIL   = LAT - 1 - (LEVELS + 1) / 2;

    // node word is {all_zero, count}; m is a level's logic, n the same after its optional register
    logic [OUT_SIZE:0]   m [0:LEVELS][0:LEAVES-1];
    logic [OUT_SIZE:0]   n [0:LEVELS][0:LEAVES-1];
    logic [OUT_SIZE-1:0] tail [0:TAIL];

    // leaf 0 holds the MSBs; only the last leaf may be narrower, so no pad bits are ever counted
    for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
        localparam int HI = SIZE - 1 - k * LZC_LEAF_W;
        localparam int W  = HI + 1 < LZC_LEAF_W ? HI + 1 : LZC_LEAF_W;
        logic [2:0] c;
        logic       z;
        lzc_leaf #(.W(W)) u_leaf (.d(din[HI -: W]), .cnt(c), .zero(z));
        assign m[0][k] = {z, OUT_SIZE'(c)};
    end

    // an upper node in a pair never contains the short leaf, so its width is a full power-of-two chunk
    for (genvar j = 1; j <= LEVELS; j++) begin : g_lvl
        localparam int                  PREV = lzc_nodes(LEAVES, j - 1);
        localparam logic [OUT_SIZE-1:0] UW   = OUT_SIZE'(LZC_LEAF_W << (j - 1));
        for (genvar k = 0; k < LEAVES; k++) begin : g_node
            if (2 * k + 1 < PREV) begin : g_pair
                logic [OUT_SIZE:0] u, l;
                assign u = n[j-1][2*k];
                assign l = n[j-1][2*k+1];
                assign m[j][k] = u[OUT_SIZE] ? {l[OUT_SIZE], UW + l[OUT_SIZE-1:0]} : {1'b0, u[OUT_SIZE-1:0]};
            end else if (2 * k < PREV) begin : g_pass
                assign m[j][k] = n[j-1][2*k];
            end else begin : g_none
                assign m[j][k] = '0;
            end
        end
    end

    // registers sit below the root on every second level, leaving at most two merges between flops
    for (genvar j = 0; j <= LEVELS; j++) begin : g_stage
        for (genvar k = 0; k < LEAVES; k++) begin : g_node
            if (j < LEVELS && (LEVELS - 1 - j) % 2 == 0 && k < lzc_nodes(LEAVES, j)) begin : g_reg
                logic [OUT_SIZE:0] q;
                // tree pipeline register
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) q <= '0;
                    else     q <= m[j][k];
                end
                assign n[j][k] = q;
            end else begin : g_wire
                assign n[j][k] = m[j][k];
            end
        end
    end

    // output delay line; its last flop drives dout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= TAIL; i++) tail[i] <= '0;
        end else begin
            tail[0] <= n[LEVELS][0][OUT_SIZE-1:0];
            for (int i = 1; i <= TAIL; i++) tail[i] <= tail[i-1];
        end
    end

    assign dout = tail[TAIL];

`ifdef PIPE_LZC_VALID_EN
    logic [LAT-1:0] vld;

    // valid shifts through LAT flops in lockstep with the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld <= '0;
        else     vld <= LAT'({vld, din_valid});
    end

    assign dout_valid = vld[LAT-1];
`endif

endmodule

// File: tb/tb_pipe_lzc.sv
// tb_pipe_lzc: directed checks of pipe_lzc at several widths, latencies and reset points
module tb_pipe_lzc;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] w;
    logic [2:0]   q6, q7;
    logic [4:0]   q19;
    logic [5:0]   q32;
    logic [6:0]   q64, q66;
    logic [7:0]   q128;
    logic         v66;
    logic         qv66;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    pipe_lzc #(.SIZE(6))   u6   (.clk(clk), .rst(rst), .din(w[5:0]),   .dout(q6));
    pipe_lzc #(.SIZE(7))   u7   (.clk(clk), .rst(rst), .din(w[6:0]),   .dout(q7));
    pipe_lzc #(.SIZE(19))  u19  (.clk(clk), .rst(rst), .din(w[18:0]),  .dout(q19));
    pipe_lzc #(.SIZE(32))  u32  (.clk(clk), .rst(rst), .din(w[31:0]),  .dout(q32));
    pipe_lzc #(.SIZE(64))  u64  (.clk(clk), .rst(rst), .din(w[63:0]),  .dout(q64));
    pipe_lzc #(.SIZE(128)) u128 (.clk(clk), .rst(rst), .din(w),        .dout(q128));
`ifdef PIPE_LZC_VALID_EN
    pipe_lzc #(.SIZE(66))  u66  (.clk(clk), .rst(rst), .din(w[65:0]),  .dout(q66), .din_valid(v66), .dout_valid(qv66));
`else
    pipe_lzc #(.SIZE(66))  u66  (.clk(clk), .rst(rst), .din(w[65:0]),  .dout(q66));
    assign qv66 = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] q_of(input int s);
        case (s)
            6:       return 32'(q6);
            7:       return 32'(q7);
            19:      return 32'(q19);
            32:      return 32'(q32);
            64:      return 32'(q64);
            66:      return 32'(q66);
            128:     return 32'(q128);
            default: return 32'hdead;
        endcase
    endfunction

    // one-hot walk then an all-zero word, streamed back to back; l is the hand-derived latency
    task automatic walk(input int s, input int l);
        for (int c = 0; c < s + l; c++) begin
            w = c < s ? 128'(1) << c : '0;
            step();
            if (c >= l - 1) check($sformatf("walk%0d_%0d", s, c - l + 1), q_of(s), c - l + 1 < s ? 32'(s - 1 - (c - l + 1)) : 32'(s));
        end
    endtask

    logic [5:0]  v6  [5] = '{6'b000001, 6'b100000, 6'b000000, 6'b010100, 6'b001111};
    int          e6  [5] = '{5, 0, 6, 1, 2};
    logic [63:0] v64 [6] = '{64'h0, 64'h8000_0000_0000_0000, 64'h1, 64'h0000_0100_0000_0000, 64'h00F0_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
    int          e64 [6] = '{64, 0, 63, 23, 8, 0};

    initial begin
        rst = 1'b1;
        w   = '1;
        v66 = 1'b0;
        repeat (3) step();
        check("rst6", q6, 0);
        check("rst64", q64, 0);
        check("rst128", q128, 0);
        #3 rst = 1'b0;
        foreach (v6[i]) begin
            w = {122'b0, v6[i]};
            step();
            check($sformatf("s6_%0d", i), q6, e6[i]);
        end
        for (int c = 0; c < 8; c++) begin
            w = c < 6 ? {64'b0, v64[c]} : '0;
            step();
            if (c >= 2) check($sformatf("s64_%0d", c - 2), q64, e64[c-2]);
        end
        walk(6, 1);
        walk(7, 2);
        walk(19, 3);
        walk(32, 3);
        walk(64, 3);
        walk(66, 3);
        walk(128, 4);
        w = 128'h1;
        repeat (3) step();
        check("pre32", q32, 31);
        check("pre64", q64, 63);
        #3 rst = 1'b1;
        #1;
        check("arst32", q32, 0);
        check("arst64", q64, 0);
        w = 128'h0001_0000;
        #2 rst = 1'b0;
        step();
        check("post32_0", q32, 0);
        step();
        check("post32_1", q32, 0);
        step();
        check("post32_2", q32, 15);
        check("post64_2", q64, 47);
`ifdef PIPE_LZC_VALID_EN
        for (int c = 0; c < 6; c++) begin
            w   = c == 0 ? 128'h1 : '0;
            v66 = c == 0;
            step();
            check($sformatf("vld66_%0d", c), 32'(qv66), c == 2 ? 1 : 0);
            if (c == 2) check("vdat66", q66, 65);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
